// File: rtl/piso_pkg.sv
// Shared types for the parallel-in, serial-out serializer.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with valid/ready word intake and
// strobe-paced bit output framed by sout_valid / sout_last.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sout_nxt;
  logic             accept;

  // The output-end bit of sreg is always the bit currently on sout.
  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic next_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-2] : word[1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  assign sout_valid = (state == SHIFT);
  assign sout_last  = sout_valid && (cnt == CNT_LAST);
  assign busy       = sout_valid;
  assign din_ready  = (state == IDLE) || (sout_last && shift_en);
  assign accept     = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      sout  <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      sout  <= sout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    sout_nxt  = sout;
    if (accept) begin
      // Also covers the no-bubble reload on the last bit of a word.
      state_nxt = SHIFT;
      sreg_nxt  = din;
      cnt_nxt   = '0;
      sout_nxt  = first_bit(din);
    end else if (state == SHIFT && shift_en) begin
      if (cnt != CNT_LAST) begin
        sreg_nxt = shift_word(sreg);
        cnt_nxt  = cnt + 1'b1;
        sout_nxt = next_bit(sreg);
      end else begin
        state_nxt = IDLE;
        sout_nxt  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first and one LSB-first
// instance share the stimulus and are checked bit by bit.
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             shift_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic [1:0]       rdy, sout, sv, sl, bsy;

  int checks = 0;
  int errors = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] fresh;
  logic [1:0] held = '0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .din(din), .din_valid(din_valid),
    .din_ready(rdy[0]), .sout(sout[0]), .sout_valid(sv[0]), .sout_last(sl[0]), .busy(bsy[0])
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .din(din), .din_valid(din_valid),
    .din_ready(rdy[1]), .sout(sout[1]), .sout_valid(sv[1]), .sout_last(sl[1]), .busy(bsy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected stream entries are {bit, last}.
  always @(posedge clk) begin
    if (rst_n) begin
      if (din_valid && rdy[0])
        for (int b = WIDTH - 1; b >= 0; b--) q0.push_back({din[b], b == 0});
      if (din_valid && rdy[1])
        for (int b = 0; b < WIDTH; b++) q1.push_back({din[b], b == WIDTH - 1});
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fresh <= '0;
    else begin
      fresh[0] <= (din_valid & rdy[0]) | (sv[0] & shift_en);
      fresh[1] <= (din_valid & rdy[1]) | (sv[1] & shift_en);
    end
  end

  task automatic mon(input int i);
    logic [1:0] e;
    int qs;
    qs = (i == 0) ? q0.size() : q1.size();
    check($sformatf("busy%0d", i), bsy[i], sv[i]);
    if (sv[i]) begin
      if (fresh[i]) begin
        if (qs == 0) check($sformatf("unexpected_valid%0d", i), sv[i], 1'b0);
        else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("sout%0d", i), sout[i], e[1]);
          check($sformatf("last%0d", i), sl[i], e[0]);
        end
      end else begin
        check($sformatf("hold_sout%0d", i), sout[i], held[i]);
      end
    end else begin
      check($sformatf("idle_sout%0d", i), sout[i], 1'b0);
      if (qs != 0) check($sformatf("valid_drop%0d", i), sv[i], 1'b1);
    end
    held[i] = sout[i];
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic send_word(input logic [WIDTH-1:0] w);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    shift_en = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Starts at the negedge of the first valid cycle after an accept.
  task automatic check_frame(input string tag);
    for (int c = 1; c <= 9; c++) begin
      #1;
      check({tag, "_valid"}, sv[0], c <= 8);
      check({tag, "_valid_lsb"}, sv[1], c <= 8);
      check({tag, "_last"}, sl[0], c == 8);
      check({tag, "_ready"}, rdy[0], c >= 8);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_sout"}, sout[i], 1'b0);
      check({tag, "_valid"}, sv[i], 1'b0);
      check({tag, "_last"}, sl[i], 1'b0);
      check({tag, "_busy"}, bsy[i], 1'b0);
      check({tag, "_ready"}, rdy[i], 1'b1);
    end
  endtask

  initial begin
    int vc, lc, rc, run, maxrun;
    bit take;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_init");
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send_word(8'hA5);
    check_frame("a5");
    send_word(8'h01);
    check_frame("w01");

    // shift_en in IDLE must not start anything
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_shift_valid", sv[0], 1'b0);
      check("idle_shift_ready", rdy[0], 1'b1);
    end

    // Back-to-back words with din_valid held
    @(negedge clk);
    din = 8'hF0;
    din_valid = 1'b1;
    shift_en = 1'b1;
    @(negedge clk);
    din = 8'h0F;
    vc = 0; lc = 0; rc = 0; run = 0; maxrun = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (k == 0) check("b2b_holdoff", rdy[0], 1'b0);
      if (sv[0]) begin
        vc++;
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (sl[0]) lc++;
      if (sv[0] && rdy[0]) rc++;
      take = din_valid && rdy[0];
      @(negedge clk);
      if (take) din_valid = 1'b0;
    end
    check("b2b_valid_cycles", vc, 16);
    check("b2b_contiguous", maxrun, 16);
    check("b2b_last_pulses", lc, 2);
    check("b2b_ready_pulses", rc, 2);

    // Paced: shift_en every 3rd edge, junk offered while not ready
    @(negedge clk);
    din = 8'hC3;
    din_valid = 1'b1;
    shift_en = 1'b0;
    vc = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      shift_en = (k % 3 == 0) && (k <= 24);
      din_valid = (k <= 23);
      din = 8'($urandom);
      #1;
      if (sv[0]) vc++;
      if (k <= 23) check("pace_holdoff", rdy[0], 1'b0);
    end
    din_valid = 1'b0;
    check("pace_word_cycles", vc, 24);

    // Reset asserted between edges in the middle of a word
    send_word(8'hFF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(8'h81);
    check_frame("after_reset");

    repeat (3) @(negedge clk);
    check("q_msb_drained", q0.size(), 0);
    check("q_lsb_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register: accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled clock on a single serial line, with valid and last-bit framing. It is the transmit-side counterpart of the team's serial-in shift-register chains. It sits between a word-oriented producer and any one-wire bit consumer, paced by an external bit-enable strobe.

## Interface
- WIDTH, 8, word width in bits; legal range is WIDTH ≥ 2.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  asynchronous reset, active-low; deasserts synchronously to clk.
- shift_en  input  1  bit-advance strobe; the serial output advances only on edges where shift_en=1.
- din  input  WIDTH  parallel word; sampled on the accept edge only.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word on this edge.
- sout  output  1  current serial bit (registered).
- sout_valid  output  1  sout carries a data bit.
- sout_last  output  1  sout is the final bit of the current word.
- busy  output  1  a word is in flight (state SHIFT).

## Operation
- State machine with two states, IDLE and SHIFT; reset enters IDLE.
- Registers: shift register sreg[WIDTH-1:0], bit counter cnt[$clog2(WIDTH)-1:0], sout.
- din_ready is combinational: (state==IDLE) | (state==SHIFT & sout_last & shift_en).
- Accept: din_valid & din_ready at a posedge. On that edge sreg ← din, cnt ← 0, state ← SHIFT, and sout ← the first bit (din[WIDTH-1] if MSB_FIRST, else din[0]).
- In SHIFT with shift_en=1 and cnt<WIDTH-1: shift sreg toward the output end, cnt ← cnt+1, sout ← next bit.
- In SHIFT with shift_en=0: all registers hold. The bit is stretched for as many cycles as shift_en stays low.
- In SHIFT with shift_en=1 and cnt==WIDTH-1:
  - If a word is accepted on the same edge, reload it with no bubble.
  - Otherwise state ← IDLE and sout ← 0.
- sout_valid = (state==SHIFT). sout_last = (state==SHIFT & cnt==WIDTH-1). busy = sout_valid.
- din is ignored whenever din_ready=0. A producer holding din_valid sees no word lost or duplicated.
- The accept does not depend on shift_en in IDLE, so a word can be loaded while shift_en=0.

## Timing
- Reset values, immediately on rst_n=0 regardless of clk: state=IDLE, sreg=0, cnt=0, sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1.
- Latency: first bit appears on sout in the cycle after the accept edge.
- Each following bit appears one cycle after each shift_en=1 edge.
- With shift_en held at 1, a word occupies exactly WIDTH cycles of sout_valid.
- Back-to-back words give a continuous sout_valid with no gap; sout_last pulses once per word.
- Boundary cases:
  - din_valid arriving while cnt<WIDTH-1 is held off, with din_ready=0.
  - shift_en=1 in IDLE has no effect.
  - cnt never exceeds WIDTH-1 and does not wrap.
  - Reset asserted mid-word aborts the word. No partial word is resumed after reset.

## Structure
- Package piso_pkg holds typedef enum logic {IDLE, SHIFT} piso_state_t. No other shared constants.
- The counter width is derived locally as $clog2(WIDTH).
- Single module with no sub-module; the shift register, counter and FSM are small enough to stay inline.

## Test plan
- Reset: drive rst_n=0 mid-simulation, asynchronously between edges → all outputs reach reset values at once; din_ready=1.
- Single word, WIDTH=8, MSB_FIRST=1, din=8'hA5, shift_en=1:
  - sout over 8 cycles = 1,0,1,0,0,1,0,1.
  - sout_last high only on cycle 8; sout_valid low on cycle 9.
- LSB-first, MSB_FIRST=0, din=8'hA5 → sout = 1,0,1,0,0,1,0,1 reversed by bit index: 1,0,1,0,0,1,0,1 for bits 0..7 of A5.
  - Repeat with din=8'h01 → 1 then seven 0s.
- Back-to-back, din_valid held with 8'hF0 then 8'h0F → 16 contiguous valid cycles: 1111000000001111 (MSB first), no bubble; din_ready high only at each last bit.
- Pacing: shift_en high every 3rd cycle, din=8'hC3 → each bit stable for 3 cycles; word completes in 24 cycles; din ignored while din_ready=0.
- Reset mid-word: assert rst_n=0 after 4 bits of 8'hFF → sout=0 and sout_valid=0 immediately; after release, a new word 8'h81 shifts from bit 1 fresh.
